bat_mem_arbiter: RTL and testbench
==================================

// Module: bat_mem_arbiter
// PURPOSE
// - Shares the single BatAmateur RAM port between two requesters:
//   CPU (controller-driven MAR/RAM strobes) and LD (program loader / debug port).
// - Sequences each access through a fixed-length RAM window and returns a one-cycle ACK.
// - Sits between the requesters and the RAM macro. The controller treats CPU_ACK as its
//   wait/advance qualifier.
// PARAMETERS
// - ADDR_W        8  RAM address width
// - DATA_W        8  RAM data width
// - ACCESS_CYCLES 1  cycles RAM_EN held per access (>=1)
// - STARVE_LIMIT  3  consecutive LD losses before LD is forced a grant (>=1)
// PORTS
// - CLK        in   1       clock; all state changes on posedge
// - RST        in   1       asynchronous, active-low reset
// - CPU_REQ    in   1       CPU access request; hold until CPU_ACK
// - CPU_RW     in   1       1=read, 0=write
// - CPU_ADDR   in   ADDR_W  CPU address
// - CPU_WDATA  in   DATA_W  CPU write data
// - CPU_ACK    out  1       one-cycle completion pulse
// - CPU_RDATA  out  DATA_W  read data; valid with CPU_ACK, held until the next CPU read
// - LD_REQ, LD_RW, LD_ADDR, LD_WDATA, LD_ACK, LD_RDATA: same as CPU_* for the loader
// - RAM_EN     out  1       RAM enable
// - RAM_RW     out  1       1=read, 0=write
// - RAM_ADDR   out  ADDR_W  RAM address
// - RAM_WDATA  out  DATA_W  RAM write data
// - RAM_RDATA  in   DATA_W  RAM read data, valid while RAM_EN && RAM_RW
// - OWNER      out  1       0=CPU, 1=LD; owner of current/last grant
// - BUSY       out  1       high in ACCESS and DONE
// BEHAVIOUR
// - Reset values: RAM_EN=0, RAM_RW=1, RAM_ADDR=0, RAM_WDATA=0, ACKs=0, RDATAs=0,
//   OWNER=0, BUSY=0, state=IDLE, starve count=0. All outputs are registered.
// - FSM: IDLE -> ACCESS -> DONE -> IDLE. Arbitration happens only in IDLE.
// - IDLE: if any REQ is high at posedge, latch the winner's RW, ADDR and WDATA onto the RAM_* outputs.
//   Same edge: set OWNER, RAM_EN=1, cnt=ACCESS_CYCLES-1, go to ACCESS. No REQ: stay in IDLE.
// - ACCESS: RAM_* outputs stay stable. If cnt!=0, decrement. If cnt==0:
//   - For a read, capture RAM_RDATA into the owner's RDATA.
//   - Set RAM_EN=0 and RAM_RW=1, pulse the owner's ACK, go to DONE.
// - DONE: ACK is high for exactly this cycle. Next edge: ACK=0, go to IDLE.
// - DONE -> IDLE gap: the requester drops or renews REQ on the edge after ACK, so no
//   duplicate grant occurs.
// - Latency: REQ sampled at edge N; RAM_EN high for cycles N+1..N+ACCESS_CYCLES;
//   ACK in cycle N+ACCESS_CYCLES+1. Throughput: one access per ACCESS_CYCLES+2 cycles.
// - Priority: CPU wins a simultaneous request unless the starvation override below is active.
// - REQ dropped mid-access: the access still completes and ACK still pulses.
//   Input changes during ACCESS are ignored because values were latched.
// - Only one ACK is ever high in a cycle. A requester never sees ACK without a prior grant.
// - Reset asserted mid-access: all state returns to reset values immediately.
//   No ACK is issued; the aborted access is lost.
// CONFIGURATION
// - BAT_ARB_STARVE_GUARD_EN defined:
//   - In IDLE, each grant to CPU while LD_REQ=1 increments the starve count (saturating at STARVE_LIMIT).
//   - When the count equals STARVE_LIMIT and LD_REQ=1, LD wins regardless of CPU_REQ.
//   - Any LD grant, or LD_REQ=0 in IDLE, clears the count.
// - Not defined: strict CPU priority; no starve counter is built; LD can starve indefinitely.
// TESTING
// - Single CPU read, ADDR=0x10, RAM_RDATA=0xA5 -> RAM_EN high cycle 1, CPU_ACK cycle 2,
//   CPU_RDATA=0xA5, OWNER=0.
// - LD write ADDR=0x20, WDATA=0x3C -> RAM_RW=0, RAM_ADDR=0x20, RAM_WDATA=0x3C for
//   ACCESS_CYCLES; LD_ACK once; CPU_ACK never.
// - CPU_REQ and LD_REQ held high from cycle 0, guard off -> only CPU granted; LD_ACK
//   never in 20 cycles.
// - Same stimulus, guard on, STARVE_LIMIT=3 -> grant order CPU, CPU, CPU, LD, CPU...
// - ACCESS_CYCLES=3, CPU_REQ dropped in the 2nd ACCESS cycle -> RAM_EN high 3 cycles;
//   CPU_ACK still pulses once.
// - RST low during ACCESS -> RAM_EN=0 and BUSY=0 immediately; no ACK.
//   After release, a new CPU read completes normally.

Source files
------------

// File: rtl/bat_mem_arbiter_if.sv
// Bus bundle for bat_mem_arbiter: CPU requester, LD requester, RAM port and status.
// slave  : arbiter side (takes requests, drives ACK/RDATA, RAM strobes, status).
// master : surrounding side (requesters and the RAM macro).
interface bat_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic              CPU_REQ;
    logic              CPU_RW;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic              CPU_ACK;
    logic [DATA_W-1:0] CPU_RDATA;

    logic              LD_REQ;
    logic              LD_RW;
    logic [ADDR_W-1:0] LD_ADDR;
    logic [DATA_W-1:0] LD_WDATA;
    logic              LD_ACK;
    logic [DATA_W-1:0] LD_RDATA;

    logic              RAM_EN;
    logic              RAM_RW;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;

    logic              OWNER;
    logic              BUSY;

    modport slave (
        input  CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA,
        input  LD_REQ, LD_RW, LD_ADDR, LD_WDATA,
        input  RAM_RDATA,
        output CPU_ACK, CPU_RDATA, LD_ACK, LD_RDATA,
        output RAM_EN, RAM_RW, RAM_ADDR, RAM_WDATA,
        output OWNER, BUSY
    );

    modport master (
        output CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA,
        output LD_REQ, LD_RW, LD_ADDR, LD_WDATA,
        output RAM_RDATA,
        input  CPU_ACK, CPU_RDATA, LD_ACK, LD_RDATA,
        input  RAM_EN, RAM_RW, RAM_ADDR, RAM_WDATA,
        input  OWNER, BUSY
    );
endinterface

// File: rtl/bat_mem_arbiter.sv
// bat_mem_arbiter: shares the single BatAmateur RAM port between the CPU and the
// loader (LD). Each access runs IDLE -> ACCESS -> DONE with a one-cycle ACK.
// Optional LD anti-starvation guard: define BAT_ARB_STARVE_GUARD_EN.
module bat_mem_arbiter #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned STARVE_LIMIT  = 3
) (
    input logic              CLK,
    input logic              RST,
    bat_mem_arbiter_if.slave bus
);
    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              ld_win;

    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_ack;
    logic              ld_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] ld_rdata;
    logic              owner;
    logic              busy;

`ifdef BAT_ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    assign ld_win = bus.LD_REQ && (!bus.CPU_REQ || (starve_cnt == STARVE_MAX));

    // Count consecutive CPU grants taken while LD was waiting; cleared on LD grant or LD idle.
    // With LD_REQ high and LD not winning, CPU_REQ must be high, so that branch is a CPU grant.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (!bus.LD_REQ || ld_win) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign ld_win = bus.LD_REQ && !bus.CPU_REQ;
`endif

    // Access sequencer: arbitrate in IDLE, hold the latched RAM window, then pulse ACK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ram_en    <= 1'b0;
            ram_rw    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.CPU_REQ || bus.LD_REQ) begin
                        if (ld_win) begin
                            ram_rw    <= bus.LD_RW;
                            ram_addr  <= bus.LD_ADDR;
                            ram_wdata <= bus.LD_WDATA;
                            owner     <= 1'b1;
                        end else begin
                            ram_rw    <= bus.CPU_RW;
                            ram_addr  <= bus.CPU_ADDR;
                            ram_wdata <= bus.CPU_WDATA;
                            owner     <= 1'b0;
                        end
                        ram_en <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= CNT_INIT;
                        state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (ram_rw) begin
                            if (owner) ld_rdata  <= bus.RAM_RDATA;
                            else       cpu_rdata <= bus.RAM_RDATA;
                        end
                        if (owner) ld_ack  <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        ram_en <= 1'b0;
                        ram_rw <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b0;
                    ld_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.RAM_EN    = ram_en;
    assign bus.RAM_RW    = ram_rw;
    assign bus.RAM_ADDR  = ram_addr;
    assign bus.RAM_WDATA = ram_wdata;
    assign bus.CPU_ACK   = cpu_ack;
    assign bus.LD_ACK    = ld_ack;
    assign bus.CPU_RDATA = cpu_rdata;
    assign bus.LD_RDATA  = ld_rdata;
    assign bus.OWNER     = owner;
    assign bus.BUSY      = busy;
endmodule

// File: tb/tb_bat_mem_arbiter.sv
// Directed self-checking bench for bat_mem_arbiter.
// Two instances share clock/reset: u1 (ACCESS_CYCLES=1) and u3 (ACCESS_CYCLES=3).
module tb_bat_mem_arbiter;
    logic CLK;
    logic RST;

    bat_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    bat_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

    bat_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(1), .STARVE_LIMIT(3)) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    bat_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(3), .STARVE_LIMIT(3)) u3 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;
    int both_ack = 0;

    // RAM model: preloaded during reset, written by u1 write accesses
    logic [7:0] mem [256];

    assign bus1.RAM_RDATA = mem[bus1.RAM_ADDR];
    assign bus3.RAM_RDATA = mem[bus3.RAM_ADDR];

    always @(posedge CLK) begin
        if (!RST) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h30] <= 8'h5A;
        end else if (bus1.RAM_EN && !bus1.RAM_RW) begin
            mem[bus1.RAM_ADDR] <= bus1.RAM_WDATA;
        end
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Both ACKs high together is never legal
    always @(negedge CLK) begin
        if ((bus1.CPU_ACK && bus1.LD_ACK) || (bus3.CPU_ACK && bus3.LD_ACK)) both_ack++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cpu_n;
        int ld_n;
        int k;
        int en_n;
        int ack_n;
        int ack_at;
        logic [7:0] seq;
        logic [7:0] exp_seq;
        int exp_cpu;
        int exp_ld;

        RST = 1'b0;
        bus1.CPU_REQ = 1'b0; bus1.CPU_RW = 1'b1; bus1.CPU_ADDR = '0; bus1.CPU_WDATA = '0;
        bus1.LD_REQ  = 1'b0; bus1.LD_RW  = 1'b1; bus1.LD_ADDR  = '0; bus1.LD_WDATA  = '0;
        bus3.CPU_REQ = 1'b0; bus3.CPU_RW = 1'b1; bus3.CPU_ADDR = '0; bus3.CPU_WDATA = '0;
        bus3.LD_REQ  = 1'b0; bus3.LD_RW  = 1'b1; bus3.LD_ADDR  = '0; bus3.LD_WDATA  = '0;
        step();
        step();

        // Reset values
        check("rst_ram_en",   32'(bus1.RAM_EN),    32'd0);
        check("rst_ram_rw",   32'(bus1.RAM_RW),    32'd1);
        check("rst_ram_addr", 32'(bus1.RAM_ADDR),  32'd0);
        check("rst_ram_wd",   32'(bus1.RAM_WDATA), 32'd0);
        check("rst_acks",     32'({bus1.CPU_ACK, bus1.LD_ACK}), 32'd0);
        check("rst_rdatas",   32'({bus1.CPU_RDATA, bus1.LD_RDATA}), 32'd0);
        check("rst_owner",    32'(bus1.OWNER),     32'd0);
        check("rst_busy",     32'(bus1.BUSY),      32'd0);
        check("rst_u3_en",    32'(bus3.RAM_EN),    32'd0);
        RST = 1'b1;
        step();

        // Single CPU read of 0x10
        bus1.CPU_REQ = 1'b1; bus1.CPU_RW = 1'b1; bus1.CPU_ADDR = 8'h10;
        step();
        check("rd_en_c1",    32'(bus1.RAM_EN),   32'd1);
        check("rd_addr_c1",  32'(bus1.RAM_ADDR), 32'h10);
        check("rd_rw_c1",    32'(bus1.RAM_RW),   32'd1);
        check("rd_ack_c1",   32'(bus1.CPU_ACK),  32'd0);
        check("rd_busy_c1",  32'(bus1.BUSY),     32'd1);
        step();
        check("rd_ack_c2",   32'(bus1.CPU_ACK),   32'd1);
        check("rd_ldack_c2", 32'(bus1.LD_ACK),    32'd0);
        check("rd_rdata",    32'(bus1.CPU_RDATA), 32'hA5);
        check("rd_owner",    32'(bus1.OWNER),     32'd0);
        check("rd_en_c2",    32'(bus1.RAM_EN),    32'd0);
        bus1.CPU_REQ = 1'b0;
        step();
        check("rd_ack_c3",   32'(bus1.CPU_ACK),   32'd0);
        check("rd_busy_c3",  32'(bus1.BUSY),      32'd0);

        // LD write 0x3C to 0x20
        bus1.LD_REQ = 1'b1; bus1.LD_RW = 1'b0; bus1.LD_ADDR = 8'h20; bus1.LD_WDATA = 8'h3C;
        step();
        check("wr_en",     32'(bus1.RAM_EN),    32'd1);
        check("wr_rw",     32'(bus1.RAM_RW),    32'd0);
        check("wr_addr",   32'(bus1.RAM_ADDR),  32'h20);
        check("wr_wdata",  32'(bus1.RAM_WDATA), 32'h3C);
        check("wr_owner",  32'(bus1.OWNER),     32'd1);
        step();
        check("wr_ldack",  32'(bus1.LD_ACK),    32'd1);
        check("wr_cpuack", 32'(bus1.CPU_ACK),   32'd0);
        check("wr_ldrd",   32'(bus1.LD_RDATA),  32'd0);
        check("wr_cpurd_held", 32'(bus1.CPU_RDATA), 32'hA5);
        bus1.LD_REQ = 1'b0;
        step();
        check("wr_ldack_off", 32'(bus1.LD_ACK), 32'd0);

        // Read back the LD write through the CPU
        bus1.CPU_REQ = 1'b1; bus1.CPU_RW = 1'b1; bus1.CPU_ADDR = 8'h20;
        step();
        step();
        check("rb_ack",   32'(bus1.CPU_ACK),   32'd1);
        check("rb_rdata", 32'(bus1.CPU_RDATA), 32'h3C);
        bus1.CPU_REQ = 1'b0;
        step();
        step();

        // Both requesters held for 20 cycles
        bus1.CPU_REQ = 1'b1; bus1.CPU_RW = 1'b1; bus1.CPU_ADDR = 8'h10;
        bus1.LD_REQ  = 1'b1; bus1.LD_RW  = 1'b1; bus1.LD_ADDR  = 8'h30;
        cpu_n = 0; ld_n = 0; k = 0; seq = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus1.CPU_ACK) cpu_n++;
            if (bus1.LD_ACK)  ld_n++;
            if ((bus1.CPU_ACK || bus1.LD_ACK) && k < 8) begin
                seq[k] = bus1.LD_ACK;
                k++;
            end
        end
`ifdef BAT_ARB_STARVE_GUARD_EN
        exp_seq = 8'b0000_1000; exp_cpu = 6; exp_ld = 1;
`else
        exp_seq = 8'b0000_0000; exp_cpu = 7; exp_ld = 0;
`endif
        check("arb_cpu_acks", 32'(cpu_n), 32'(exp_cpu));
        check("arb_ld_acks",  32'(ld_n),  32'(exp_ld));
        check("arb_order",    32'(seq),   32'(exp_seq));
        bus1.CPU_REQ = 1'b0; bus1.LD_REQ = 1'b0;
        step();
        step();
        check("arb_idle_busy", 32'(bus1.BUSY), 32'd0);

        // ACCESS_CYCLES=3, CPU_REQ dropped and address scrambled in 2nd ACCESS cycle
        bus3.CPU_REQ = 1'b1; bus3.CPU_RW = 1'b1; bus3.CPU_ADDR = 8'h10;
        en_n = 0; ack_n = 0; ack_at = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus3.RAM_EN) en_n++;
            if (bus3.CPU_ACK) begin
                ack_n++;
                ack_at = i;
            end
            if (i == 2) begin
                bus3.CPU_REQ  = 1'b0;
                bus3.CPU_ADDR = 8'hFF;
            end
            if (i == 3) check("ac3_addr_stable", 32'(bus3.RAM_ADDR), 32'h10);
        end
        check("ac3_en_cycles", 32'(en_n),   32'd3);
        check("ac3_acks",      32'(ack_n),  32'd1);
        check("ac3_ack_cycle", 32'(ack_at), 32'd4);
        check("ac3_rdata",     32'(bus3.CPU_RDATA), 32'hA5);

        // Reset asserted in the middle of an access
        bus3.CPU_REQ = 1'b1; bus3.CPU_RW = 1'b1; bus3.CPU_ADDR = 8'h30;
        step();
        step();
        check("abort_pre_en", 32'(bus3.RAM_EN), 32'd1);
        RST = 1'b0;
        bus3.CPU_REQ = 1'b0;
        #1;
        check("abort_en",    32'(bus3.RAM_EN),  32'd0);
        check("abort_busy",  32'(bus3.BUSY),    32'd0);
        check("abort_ack",   32'(bus3.CPU_ACK), 32'd0);
        check("abort_rdata", 32'(bus3.CPU_RDATA), 32'd0);
        step();
        step();
        RST = 1'b1;
        ack_n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus3.CPU_ACK || bus3.LD_ACK) ack_n++;
        end
        check("abort_no_ack", 32'(ack_n), 32'd0);

        // Fresh CPU read after reset release, bounded wait for ACK
        bus3.CPU_REQ = 1'b1; bus3.CPU_RW = 1'b1; bus3.CPU_ADDR = 8'h30;
        ack_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus3.CPU_ACK) begin
                ack_at = i;
                break;
            end
        end
        check("post_rst_ack_cycle", 32'(ack_at), 32'd4);
        check("post_rst_rdata",     32'(bus3.CPU_RDATA), 32'h5A);
        bus3.CPU_REQ = 1'b0;
        step();
        step();

        check("single_ack", 32'(both_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
